pix_packer: RTL

Downstream consumer of the pixel FIFO in the image-sensor path. Pops 12-bit pixels from the FIFO using its `q`/`qValid`/`qout` interface and packs them densely into 16-bit words: 4 pixels become 3 words. Drives a valid/ready word stream toward the RAM writer. An optional end-of-frame flush emits the final partial word, zero-padded.

---
 rtl/pix_packer_pkg.sv | 9 +
 rtl/pix_word_reg.sv | 33 +++
 rtl/pix_packer.sv | 94 +++++++++
 3 files changed

// File: rtl/pix_packer_pkg.sv
// pix_packer_pkg: shared widths and types for the 12-to-16 bit pixel packer
package pix_packer_pkg;
    localparam int PixWidth  = 12;
    localparam int WordWidth = 16;
    localparam int AccWidth  = 24;
    typedef logic [PixWidth-1:0]  pix_t;
    typedef logic [WordWidth-1:0] word_t;
    typedef logic [4:0]           accbits_t;
endpackage

// File: rtl/pix_word_reg.sv
// pix_word_reg: valid/ready holding register for the packed output word
module pix_word_reg
    import pix_packer_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_load,
    input  word_t i_data,
    input  logic  i_ready,
    output word_t o_word,
    output logic  o_valid,
    output logic  o_free
);
    word_t r_word;
    logic  r_valid;

    assign o_free  = !r_valid | i_ready;
    assign o_word  = r_word;
    assign o_valid = r_valid;

    // load a new word when the core emits, otherwise drop valid once consumed
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_word  <= i_data;
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/pix_packer.sv
// pix_packer: packs 12-bit FIFO pixels into 16-bit words (4 pixels -> 3 words); PIX_PACKER_FLUSH_EN enables end-of-frame flush
module pix_packer #(
    parameter int PixWidth  = 12,
    parameter int WordWidth = 16
) (
    input  logic                 pix_clk,
    input  logic                 pix_rst_n,
    input  logic [PixWidth-1:0]  q,
    input  logic                 qValid,
    output logic                 qout,
    output logic [WordWidth-1:0] word,
    output logic                 wordValid,
    input  logic                 wordReady,
    input  logic                 flush,
    output logic                 flushDone
);
    import pix_packer_pkg::*;

    if (PixWidth != 12 || WordWidth != 16) begin : g_bad_width
        $error("pix_packer supports only PixWidth=12 and WordWidth=16");
    end

    logic [AccWidth-1:0] r_acc, w_acc_nxt;
    accbits_t            r_bits, w_bits_nxt, w_post;
    logic                w_free, w_emit, w_femit, w_pop;
    word_t               w_word;

    assign w_emit = (r_bits >= 5'd16) & w_free;
    assign w_post = r_bits - (w_emit ? 5'd16 : 5'd0);
    assign w_pop  = qValid & (w_post <= 5'd12) & pix_rst_n;
    assign qout   = w_pop;
    assign word   = w_word;

`ifdef PIX_PACKER_FLUSH_EN
    logic r_pend, r_done, w_done;

    assign w_femit   = r_pend & !qValid & (r_bits != 5'd0) & (r_bits < 5'd16) & w_free;
    assign w_done    = r_pend & !qValid & (r_bits == 5'd0);
    assign flushDone = r_done;

    // track a pending flush request and pulse done once the accumulator is empty
    always_ff @(posedge pix_clk or negedge pix_rst_n) begin
        if (!pix_rst_n) begin
            r_pend <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_pend <= w_done ? 1'b0 : (r_pend | flush);
            r_done <= w_done;
        end
    end
`else
    logic w_unused_flush;

    assign w_unused_flush = flush;
    assign w_femit        = 1'b0;
    assign flushDone      = 1'b0;
`endif

    // shift out an emitted word, clear on flush, then append the popped pixel at the fill level
    always_comb begin
        w_acc_nxt  = w_emit ? (r_acc >> WordWidth) : r_acc;
        w_bits_nxt = w_post;
        if (w_femit) begin
            w_acc_nxt  = '0;
            w_bits_nxt = '0;
        end
        if (w_pop) begin
            w_acc_nxt  = w_acc_nxt | ({{(AccWidth-PixWidth){1'b0}}, q} << w_post);
            w_bits_nxt = w_post + 5'd12;
        end
    end

    // accumulator and fill level
    always_ff @(posedge pix_clk or negedge pix_rst_n) begin
        if (!pix_rst_n) begin
            r_acc  <= '0;
            r_bits <= '0;
        end else begin
            r_acc  <= w_acc_nxt;
            r_bits <= w_bits_nxt;
        end
    end

    pix_word_reg u_word_reg (
        .i_clk   (pix_clk),
        .i_rst_n (pix_rst_n),
        .i_load  (w_emit | w_femit),
        .i_data  (r_acc[WordWidth-1:0]),
        .i_ready (wordReady),
        .o_word  (w_word),
        .o_valid (wordValid),
        .o_free  (w_free)
    );
endmodule
